// File: rtl/jk_ff_bank_if.sv
// Bus bundle for jk_ff_bank: raw switch inputs, control strobes and the
// flip-flop outputs. The switch/control side drives through the master
// modport and the flip-flop bank sits on the slave modport.
interface jk_ff_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         step;
    logic         hold;
    logic         load;
    logic [N-1:0] load_data;
    logic [N-1:0] q;
    logic [N-1:0] qn;
    logic [N-1:0] changed;

    modport master (
        output j,
        output k,
        output step,
        output hold,
        output load,
        output load_data,
        input  q,
        input  qn,
        input  changed
    );

    modport slave (
        input  j,
        input  k,
        input  step,
        input  hold,
        input  load,
        input  load_data,
        output q,
        output qn,
        output changed
    );
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of N independent clocked JK flip-flops fed from raw board switches.
// Every J and K bit is synchronised and debounced on its own. A channel acts
// once when its debounced {J,K} pair changes, or when step is pulsed, so a
// held 11 toggles exactly once instead of oscillating. Parallel load and a
// global hold sit above the JK action, and changed flags every bit that
// moved on the previous edge.
module jk_ff_bank #(
    parameter int           N               = 4,
    parameter int           SYNC_STAGES     = 2,
    parameter int           DEBOUNCE_CYCLES = 16,
    parameter logic [N-1:0] RESET_VALUE     = '0
) (
    input logic         clk,
    input logic         reset,
    jk_ff_bank_if.slave bus
);

    // J bits occupy the low half of the combined input vector, K bits the high half.
    localparam int W          = 2 * N;
    localparam int CW         = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0] raw_in;
    logic [W-1:0] synced;
    logic [W-1:0] accepted;
    logic [W-1:0] accepted_prev;

    logic [N-1:0] jd;
    logic [N-1:0] kd;
    logic [N-1:0] jd_prev;
    logic [N-1:0] kd_prev;
    logic [N-1:0] event_vec;

    logic [N-1:0] q_reg;
    logic [N-1:0] qn_reg;
    logic [N-1:0] changed_reg;
    logic [N-1:0] q_next;

    assign raw_in = {bus.k, bus.j};

    // Per input bit: a synchroniser chain followed by a stability counter.
    for (genvar b = 0; b < W; b++) begin : g_input
        logic [SYNC_STAGES-1:0] chain;
        logic [CW-1:0]          count;
        logic                   stable_bit;

        // Shift the raw switch level through the synchroniser flops; the top stage is the clean copy.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], raw_in[b]};
            end
        end

        // Accept a new level only after it has disagreed with the accepted one for DEBOUNCE_CYCLES cycles in a row.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count      <= '0;
                stable_bit <= 1'b0;
            end else if (chain[SYNC_STAGES-1] == stable_bit) begin
                count <= '0;
            end else if (count == COUNT_LAST) begin
                stable_bit <= chain[SYNC_STAGES-1];
                count      <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end

        assign synced[b]   = chain[SYNC_STAGES-1];
        assign accepted[b] = stable_bit;
    end

    assign jd      = accepted[N-1:0];
    assign kd      = accepted[W-1:N];
    assign jd_prev = accepted_prev[N-1:0];
    assign kd_prev = accepted_prev[W-1:N];

    // Remember last cycle's debounced pairs so a change can be seen as a single event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accepted_prev <= '0;
        end else begin
            accepted_prev <= accepted;
        end
    end

    // A channel has an event when its pair moved or step is asserted; both together still count once.
    assign event_vec = (jd ^ jd_prev) | (kd ^ kd_prev) | {N{bus.step}};

    // Next flip-flop state: load beats hold, hold beats events, and events apply the JK table.
    always_comb begin
        q_next = q_reg;
        if (bus.load) begin
            q_next = bus.load_data;
        end else if (!bus.hold) begin
            for (int i = 0; i < N; i++) begin
                if (event_vec[i]) begin
                    case ({jd[i], kd[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   q_next[i] = ~q_reg[i];
                        default: q_next[i] = q_reg[i];
                    endcase
                end
            end
        end
    end

    // Register q, its complement and the one-cycle change flags together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg       <= RESET_VALUE;
            qn_reg      <= ~RESET_VALUE;
            changed_reg <= '0;
        end else begin
            q_reg       <= q_next;
            qn_reg      <= ~q_next;
            changed_reg <= q_next ^ q_reg;
        end
    end

    assign bus.q       = q_reg;
    assign bus.qn      = qn_reg;
    assign bus.changed = changed_reg;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Self-checking bench for jk_ff_bank with two channels, two-flop
// synchronisers and a four-cycle debounce. A history-window reference model
// predicts q, qn and changed every cycle; directed steps walk through the
// latency, toggle, glitch, priority, hold and async-reset cases before a
// randomised stretch.
module tb_jk_ff_bank;

    localparam int           N    = 2;
    localparam int           SYNC = 2;
    localparam int           DEB  = 4;
    localparam logic [N-1:0] RV   = 2'b00;
    localparam int           W    = 2 * N;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    jk_ff_bank_if #(.N(N)) bus ();

    jk_ff_bank #(
        .N(N),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VALUE(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock with a 10 time-unit period.
    always #5 clk = ~clk;

    // Reference model state: flip-flop outputs, accepted switch levels and sample histories.
    logic [N-1:0] mQ;
    logic [N-1:0] mQn;
    logic [N-1:0] mChanged;
    logic [W-1:0] mAcc;
    logic [W-1:0] mPrevAcc;
    logic [W-1:0] rawHist[$];
    logic [W-1:0] syncHist[$];

    task automatic modelReset();
        mQ       = RV;
        mQn      = ~RV;
        mChanged = '0;
        mAcc     = '0;
        mPrevAcc = '0;
        rawHist  = {};
        syncHist = {};
        for (int i = 0; i < SYNC - 1; i++) rawHist.push_back('0);
        for (int i = 0; i < DEB; i++) syncHist.push_back('0);
    endtask

    // One rising edge of the reference: the inputs are the ones presented at that edge.
    task automatic modelEdge();
        logic [N-1:0] jdM, kdM, jpM, kpM, qNew;
        logic [W-1:0] newAcc, syncNow, dropped;
        logic         allDiffer;
        jdM  = mAcc[N-1:0];
        kdM  = mAcc[W-1:N];
        jpM  = mPrevAcc[N-1:0];
        kpM  = mPrevAcc[W-1:N];
        qNew = mQ;
        if (bus.load) begin
            qNew = bus.load_data;
        end else if (!bus.hold) begin
            for (int i = 0; i < N; i++) begin
                if (bus.step || jdM[i] != jpM[i] || kdM[i] != kpM[i]) begin
                    if (jdM[i] && kdM[i]) qNew[i] = ~mQ[i];
                    else if (jdM[i])      qNew[i] = 1'b1;
                    else if (kdM[i])      qNew[i] = 1'b0;
                end
            end
        end
        mChanged = qNew ^ mQ;
        mQ       = qNew;
        mQn      = ~qNew;
        mPrevAcc = mAcc;
        // A bit flips once its last DEB synchronised samples all disagree with the accepted level.
        newAcc = mAcc;
        for (int b = 0; b < W; b++) begin
            allDiffer = 1'b1;
            foreach (syncHist[x]) begin
                if (syncHist[x][b] == mAcc[b]) allDiffer = 1'b0;
            end
            if (allDiffer) newAcc[b] = ~mAcc[b];
        end
        mAcc = newAcc;
        rawHist.push_back({bus.k, bus.j});
        syncNow = rawHist.pop_front();
        syncHist.push_back(syncNow);
        dropped = syncHist.pop_front();
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_q"}, bus.q, mQ);
        checkOutput({tag, "_qn"}, bus.qn, mQn);
        checkOutput({tag, "_changed"}, bus.changed, mChanged);
    endtask

    // Called on a falling edge: drive inputs, cross one rising edge, then compare on the next falling edge.
    task automatic applyStimulus(input logic [N-1:0] jv, input logic [N-1:0] kv, input logic st,
                                 input logic hd, input logic ld, input logic [N-1:0] dv, input string tag);
        bus.j         = jv;
        bus.k         = kv;
        bus.step      = st;
        bus.hold      = hd;
        bus.load      = ld;
        bus.load_data = dv;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkModel(tag);
    endtask

    task automatic idle(input int n, input logic [N-1:0] jv, input logic [N-1:0] kv);
        for (int c = 0; c < n; c++) applyStimulus(jv, kv, 1'b0, 1'b0, 1'b0, '0, "idle");
    endtask

    // Directed steps followed by a randomised stretch, all compared against the model.
    initial begin
        int           pulses;
        int           holdLen;
        logic [N-1:0] rj, rk;

        reset         = 1'b1;
        bus.j         = '0;
        bus.k         = '0;
        bus.step      = 1'b0;
        bus.hold      = 1'b0;
        bus.load      = 1'b0;
        bus.load_data = '0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_q", bus.q, 2'b00);
        checkOutput("reset_qn", bus.qn, 2'b11);
        checkOutput("reset_changed", bus.changed, 2'b00);

        // Set on channel 0 lands exactly SYNC+DEB+1 edges after the switch moves.
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, '0, "lat");
            if (e == 6) checkBit("lat_q0_edge6", bus.q[0], 1'b0);
        end
        checkBit("lat_q0_edge7", bus.q[0], 1'b1);
        checkBit("lat_qn0_edge7", bus.qn[0], 1'b0);
        checkBit("lat_changed0", bus.changed[0], 1'b1);
        checkBit("lat_q1", bus.q[1], 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, '0, "lat_after");
        checkBit("lat_changed0_drop", bus.changed[0], 1'b0);

        // Held 11 toggles once, then each step toggles again.
        idle(10, 2'b00, 2'b01);
        checkBit("tog_q0_cleared", bus.q[0], 1'b0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, '0, "tog");
            pulses += int'(bus.changed[0]);
        end
        checkOutput("tog_pulses", N'(pulses), 2'b01);
        checkBit("tog_q0_once", bus.q[0], 1'b1);
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, '0, "step1");
        checkBit("step1_q0", bus.q[0], 1'b0);
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, '0, "step2");
        checkBit("step2_q0", bus.q[0], 1'b1);

        // A 3-cycle glitch on k[1] is ignored; a 6-cycle pulse resets q[1].
        idle(10, 2'b10, 2'b00);
        checkBit("glitch_q1_set", bus.q[1], 1'b1);
        idle(10, 2'b00, 2'b00);
        pulses = 0;
        for (int c = 0; c < 13; c++) begin
            applyStimulus(2'b00, (c < 3) ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0, '0, "glitch");
            pulses += int'(bus.changed[1]);
        end
        checkOutput("glitch_pulses", N'(pulses), 2'b00);
        checkBit("glitch_q1_kept", bus.q[1], 1'b1);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(2'b00, (e <= 6) ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0, '0, "pulse6");
            if (e == 6) checkBit("pulse6_q1_edge6", bus.q[1], 1'b1);
        end
        checkBit("pulse6_q1_edge7", bus.q[1], 1'b0);
        idle(10, 2'b00, 2'b00);

        // Load wins over hold and step, and hold then swallows a step.
        idle(10, 2'b11, 2'b11);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, "prio_pre");
        checkOutput("prio_pre_q", bus.q, 2'b00);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, "prio_load");
        checkOutput("prio_load_q", bus.q, 2'b10);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, "prio_hold");
        checkOutput("prio_hold_q", bus.q, 2'b10);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, "prio_quiet");
        checkOutput("prio_quiet_q", bus.q, 2'b10);

        // An event that lands while hold is high is dropped, not deferred.
        idle(10, 2'b00, 2'b00);
        checkBit("hdrop_q0_start", bus.q[0], 1'b0);
        for (int c = 0; c < 10; c++) applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, '0, "hdrop_hold");
        idle(3, 2'b01, 2'b00);
        checkBit("hdrop_q0_kept", bus.q[0], 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, '0, "hdrop_step");
        checkBit("hdrop_q0_step", bus.q[0], 1'b1);

        // Async reset in the middle of a debounce clears outputs before any clock edge.
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, "areset_load");
        checkOutput("areset_load_q", bus.q, 2'b11);
        for (int c = 0; c < 3; c++) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, '0, "areset_deb");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_q", bus.q, 2'b00);
        checkOutput("areset_qn", bus.qn, 2'b11);
        checkOutput("areset_changed", bus.changed, 2'b00);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        idle(10, 2'b00, 2'b00);
        checkOutput("areset_after_q", bus.q, 2'b00);

        // Random switch patterns with random hold lengths, plus sparse step/hold/load.
        for (int it = 0; it < 60; it++) begin
            rj      = N'($urandom);
            rk      = N'($urandom);
            holdLen = $urandom_range(1, 10);
            for (int c = 0; c < holdLen; c++) begin
                applyStimulus(rj, rk, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                              ($urandom_range(0, 11) == 0), N'($urandom), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
